// File: rtl/sb_rdi_cfg_ingress_if.sv
// Adapter configuration beat bus and sideband TX FIFO write port of the
// RDI cfg ingress stage. The slave side is the ingress block; the master
// side is the environment (adapter beats plus FIFO status).
interface sb_rdi_cfg_ingress_if #(
  parameter int NC = 32
);
  logic [NC-1:0] lp_cfg;
  logic          lp_cfg_vld;
  logic          fifo_full;
  logic          fifo_wr_en;
  logic [63:0]   fifo_wdata;

  modport master (
    output lp_cfg, lp_cfg_vld, fifo_full,
    input  fifo_wr_en, fifo_wdata
  );

  modport slave (
    input  lp_cfg, lp_cfg_vld, fifo_full,
    output fifo_wr_en, fifo_wdata
  );
endinterface

// File: rtl/sb_rdi_cfg_ingress.sv
// Sideband RDI cfg ingress: assembles NC-bit adapter beats into 64-bit words,
// writes every message to the TX FIFO as exactly two entries (header plus
// data or zero pad), and keeps the adapter credit count.
//
// state | meaning
// HDR   | collecting header beats
// DATA  | header written, collecting the data word
// PAD   | header written, zero pad word due this cycle
module sb_rdi_cfg_ingress #(
  parameter int NC      = 32,
  parameter int CREDITS = 32,
  parameter int CW      = 6
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_pl_inband_pres,
  input  logic                 i_pl_cfg_crd,
  sb_rdi_cfg_ingress_if.slave  cfg,
  output logic [CW-1:0]        o_credit_cnt,
  output logic                 o_crd_underflow_err,
  output logic                 o_crd_overflow_err,
  output logic                 o_fifo_ovf_err
);

  localparam int BEATS = 64 / NC;
  localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [CW-1:0] CRD_MAX = CW'(CREDITS);

  typedef enum logic [1:0] {
    HDR  = 2'd0,
    DATA = 2'd1,
    PAD  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [63:0]     asm_q, asm_d;
  logic            wr_pend_q, wr_pend_d;
  logic [63:0]     wdata_q, wdata_d;
  logic            drop_q, drop_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic            uf_err_q, uf_err_d;
  logic            of_err_q, of_err_d;
  logic            ovf_err_q, ovf_err_d;

  logic beat_vld;
  logic last_beat;
  logic word_done;
  logic hdr_done;
  logic hdr_ok;

  assign beat_vld  = cfg.lp_cfg_vld & i_pl_inband_pres;
  assign last_beat = (beat_q == BW'(BEATS - 1));
  assign word_done = beat_vld & last_beat;
  assign hdr_done  = word_done & (state_q == HDR);
  assign hdr_ok    = hdr_done & (credit_q != '0);

  function automatic logic has_data(input logic [4:0] opc);
    case (opc)
      5'b00001, 5'b00101, 5'b01001, 5'b01101,
      5'b10001, 5'b11001, 5'b11011: has_data = 1'b1;
      default:                      has_data = 1'b0;
    endcase
  endfunction

  // Next-state, beat assembly, write scheduling, credits and error flags.
  always_comb begin
    state_d   = state_q;
    beat_d    = beat_q;
    asm_d     = asm_q;
    wr_pend_d = 1'b0;
    wdata_d   = wdata_q;
    drop_d    = drop_q;
    credit_d  = credit_q;
    uf_err_d  = uf_err_q;
    of_err_d  = of_err_q;
    ovf_err_d = ovf_err_q;

    // Beat counter runs independently of the FSM so a header beat that
    // arrives during PAD is kept.
    if (beat_vld) begin
      for (int k = 0; k < BEATS; k++) begin
        if (beat_q == BW'(k)) asm_d[k*NC +: NC] = cfg.lp_cfg;
      end
      beat_d = last_beat ? '0 : beat_q + BW'(1);
    end

    case (state_q)
      HDR: begin
        if (word_done) begin
          // Out of credits: the whole message is swallowed, including its
          // data or pad entry, so the FIFO never sees half a message.
          drop_d    = (credit_q == '0);
          wr_pend_d = (credit_q != '0);
          wdata_d   = asm_d;
          state_d   = has_data(asm_d[4:0]) ? DATA : PAD;
        end
      end
      DATA: begin
        if (word_done) begin
          wr_pend_d = ~drop_q;
          wdata_d   = asm_d;
          state_d   = HDR;
        end
      end
      PAD: begin
        wr_pend_d = ~drop_q;
        wdata_d   = '0;
        state_d   = HDR;
      end
      default: state_d = HDR;
    endcase

    if (hdr_done && credit_q == '0) uf_err_d = 1'b1;

    // Debit and return in the same cycle cancel out.
    if (hdr_ok && !i_pl_cfg_crd) begin
      credit_d = credit_q - CW'(1);
    end else if (!hdr_ok && i_pl_cfg_crd) begin
      if (credit_q == CRD_MAX) of_err_d = 1'b1;
      else                     credit_d = credit_q + CW'(1);
    end

    if (wr_pend_q && i_pl_inband_pres && cfg.fifo_full) ovf_err_d = 1'b1;

    // Link down: flush any partial message and restore the full credit pool.
    if (!i_pl_inband_pres) begin
      state_d   = HDR;
      beat_d    = '0;
      asm_d     = '0;
      wr_pend_d = 1'b0;
      drop_d    = 1'b0;
      credit_d  = CRD_MAX;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= HDR;
      beat_q    <= '0;
      asm_q     <= '0;
      wr_pend_q <= 1'b0;
      wdata_q   <= '0;
      drop_q    <= 1'b0;
      credit_q  <= CRD_MAX;
      uf_err_q  <= 1'b0;
      of_err_q  <= 1'b0;
      ovf_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      beat_q    <= beat_d;
      asm_q     <= asm_d;
      wr_pend_q <= wr_pend_d;
      wdata_q   <= wdata_d;
      drop_q    <= drop_d;
      credit_q  <= credit_d;
      uf_err_q  <= uf_err_d;
      of_err_q  <= of_err_d;
      ovf_err_q <= ovf_err_d;
    end
  end

  // A full FIFO swallows the write; the FSM has already moved on.
  assign cfg.fifo_wr_en       = wr_pend_q & i_pl_inband_pres & ~cfg.fifo_full;
  assign cfg.fifo_wdata       = wdata_q;
  assign o_credit_cnt         = credit_q;
  assign o_crd_underflow_err  = uf_err_q;
  assign o_crd_overflow_err   = of_err_q;
  assign o_fifo_ovf_err       = ovf_err_q;

endmodule

// File: tb/tb_sb_rdi_cfg_ingress.sv
// Directed bench for sb_rdi_cfg_ingress: one NC=32 and one NC=16 instance.
module tb_sb_rdi_cfg_ingress;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic pres = 1'b1;
  logic crd = 1'b0;

  logic [5:0] crd_a, crd_b;
  logic uf_a, of_a, ovf_a, uf_b, of_b, ovf_b;

  int checks = 0;
  int errors = 0;

  sb_rdi_cfg_ingress_if #(.NC(32)) if_a ();
  sb_rdi_cfg_ingress_if #(.NC(16)) if_b ();

  sb_rdi_cfg_ingress #(.NC(32), .CREDITS(32), .CW(6)) u_a (
    .i_clk(clk), .i_rst(rst), .i_pl_inband_pres(pres), .i_pl_cfg_crd(crd),
    .cfg(if_a), .o_credit_cnt(crd_a), .o_crd_underflow_err(uf_a),
    .o_crd_overflow_err(of_a), .o_fifo_ovf_err(ovf_a)
  );

  sb_rdi_cfg_ingress #(.NC(16), .CREDITS(32), .CW(6)) u_b (
    .i_clk(clk), .i_rst(rst), .i_pl_inband_pres(pres), .i_pl_cfg_crd(crd),
    .cfg(if_b), .o_credit_cnt(crd_b), .o_crd_underflow_err(uf_b),
    .o_crd_overflow_err(of_b), .o_fifo_ovf_err(ovf_b)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    if_a.lp_cfg_vld = 1'b0;
    if_b.lp_cfg_vld = 1'b0;
    if_a.fifo_full = 1'b0;
    if_b.fifo_full = 1'b0;
    crd = 1'b0;
    pres = 1'b1;
    step();
    rst = 1'b0;
  endtask

  // Drives one valid NC=32 beat for one cycle.
  task automatic beat_a(input logic [31:0] d);
    if_a.lp_cfg = d;
    if_a.lp_cfg_vld = 1'b1;
    step();
    if_a.lp_cfg_vld = 1'b0;
  endtask

  task automatic beat_b(input logic [15:0] d);
    if_b.lp_cfg = d;
    if_b.lp_cfg_vld = 1'b1;
    step();
    if_b.lp_cfg_vld = 1'b0;
  endtask

  // No-data message on the NC=32 instance followed by idle cycles.
  task automatic msg_nodata_a(input logic [31:0] hi);
    beat_a(32'h0000_0020);
    beat_a(hi);
    step();
    step();
  endtask

  task automatic test_reset();
    if_a.lp_cfg = '0;
    if_b.lp_cfg = '0;
    do_reset();
    checks++; if (if_a.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 0", if_a.fifo_wr_en); end
    checks++; if (if_a.fifo_wdata !== 64'h0) begin errors++; $display("FAIL reset_wdata: got %h expected 0", if_a.fifo_wdata); end
    checks++; if (crd_a !== 6'd32) begin errors++; $display("FAIL reset_credits: got %0d expected 32", crd_a); end
    checks++; if ({uf_a, of_a, ovf_a} !== 3'b000) begin errors++; $display("FAIL reset_errs: got %b expected 000", {uf_a, of_a, ovf_a}); end
  endtask

  task automatic test_data_msg();
    do_reset();
    beat_a(32'h0000_0005);
    checks++; if (if_a.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL data_early_wr: got %b expected 0", if_a.fifo_wr_en); end
    beat_a(32'hAABB_CCDD);
    checks++; if (if_a.fifo_wr_en !== 1'b1 || if_a.fifo_wdata !== 64'hAABBCCDD_00000005) begin errors++; $display("FAIL data_hdr_wr: got %b/%h expected 1/aabbccdd00000005", if_a.fifo_wr_en, if_a.fifo_wdata); end
    checks++; if (crd_a !== 6'd31) begin errors++; $display("FAIL data_debit: got %0d expected 31", crd_a); end
    beat_a(32'h1111_1111);
    checks++; if (if_a.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL data_no_pad: got %b expected 0", if_a.fifo_wr_en); end
    beat_a(32'h2222_2222);
    checks++; if (if_a.fifo_wr_en !== 1'b1 || if_a.fifo_wdata !== 64'h22222222_11111111) begin errors++; $display("FAIL data_word_wr: got %b/%h expected 1/2222222211111111", if_a.fifo_wr_en, if_a.fifo_wdata); end
    step();
    checks++; if (if_a.fifo_wr_en !== 1'b0 || crd_a !== 6'd31) begin errors++; $display("FAIL data_idle: got %b/%0d expected 0/31", if_a.fifo_wr_en, crd_a); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    if_a.lp_cfg_vld = 1'b1;
    if_a.lp_cfg = 32'h0000_0100; step();
    if_a.lp_cfg = 32'h0000_0001; step();
    checks++; if (if_a.fifo_wr_en !== 1'b1 || if_a.fifo_wdata !== 64'h00000001_00000100) begin errors++; $display("FAIL b2b_hdr1: got %b/%h expected 1/0000000100000100", if_a.fifo_wr_en, if_a.fifo_wdata); end
    if_a.lp_cfg = 32'h0000_0220; step();
    checks++; if (if_a.fifo_wr_en !== 1'b1 || if_a.fifo_wdata !== 64'h0) begin errors++; $display("FAIL b2b_pad1: got %b/%h expected 1/0", if_a.fifo_wr_en, if_a.fifo_wdata); end
    if_a.lp_cfg = 32'h0000_0002; step();
    checks++; if (if_a.fifo_wr_en !== 1'b1 || if_a.fifo_wdata !== 64'h00000002_00000220) begin errors++; $display("FAIL b2b_hdr2: got %b/%h expected 1/0000000200000220", if_a.fifo_wr_en, if_a.fifo_wdata); end
    if_a.lp_cfg_vld = 1'b0; step();
    checks++; if (if_a.fifo_wr_en !== 1'b1 || if_a.fifo_wdata !== 64'h0) begin errors++; $display("FAIL b2b_pad2: got %b/%h expected 1/0", if_a.fifo_wr_en, if_a.fifo_wdata); end
    step();
    checks++; if (if_a.fifo_wr_en !== 1'b0 || crd_a !== 6'd30) begin errors++; $display("FAIL b2b_end: got %b/%0d expected 0/30", if_a.fifo_wr_en, crd_a); end
  endtask

  task automatic test_underflow();
    do_reset();
    for (int i = 0; i < 32; i++) msg_nodata_a(32'(i));
    checks++; if (crd_a !== 6'd0 || uf_a !== 1'b0) begin errors++; $display("FAIL uf_exhausted: got %0d/%b expected 0/0", crd_a, uf_a); end
    beat_a(32'h0000_0020);
    beat_a(32'h0000_00EE);
    checks++; if (if_a.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL uf_hdr_dropped: got %b expected 0", if_a.fifo_wr_en); end
    step();
    checks++; if (if_a.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL uf_pad_dropped: got %b expected 0", if_a.fifo_wr_en); end
    checks++; if (uf_a !== 1'b1 || crd_a !== 6'd0) begin errors++; $display("FAIL uf_flag: got %b/%0d expected 1/0", uf_a, crd_a); end
    crd = 1'b1; step(); crd = 1'b0;
    checks++; if (crd_a !== 6'd1) begin errors++; $display("FAIL uf_return: got %0d expected 1", crd_a); end
  endtask

  task automatic test_credit_edges();
    do_reset();
    checks++; if (uf_a !== 1'b0) begin errors++; $display("FAIL edge_uf_cleared: got %b expected 0", uf_a); end
    for (int i = 0; i < 22; i++) msg_nodata_a(32'(i));
    checks++; if (crd_a !== 6'd10) begin errors++; $display("FAIL edge_at10: got %0d expected 10", crd_a); end
    beat_a(32'h0000_0020);
    if_a.lp_cfg = 32'h0000_0033; if_a.lp_cfg_vld = 1'b1; crd = 1'b1;
    step();
    if_a.lp_cfg_vld = 1'b0; crd = 1'b0;
    checks++; if (crd_a !== 6'd10 || if_a.fifo_wr_en !== 1'b1) begin errors++; $display("FAIL edge_coincident: got %0d/%b expected 10/1", crd_a, if_a.fifo_wr_en); end
    do_reset();
    crd = 1'b1; step(); crd = 1'b0;
    checks++; if (of_a !== 1'b1 || crd_a !== 6'd32) begin errors++; $display("FAIL edge_overflow: got %b/%0d expected 1/32", of_a, crd_a); end
  endtask

  task automatic test_presence_drop();
    do_reset();
    beat_a(32'h0000_0001);
    beat_a(32'h0000_CAFE);
    checks++; if (if_a.fifo_wr_en !== 1'b1 || crd_a !== 6'd31) begin errors++; $display("FAIL pres_hdr: got %b/%0d expected 1/31", if_a.fifo_wr_en, crd_a); end
    beat_a(32'h0000_1234);
    pres = 1'b0;
    if_a.lp_cfg = 32'hDEAD_BEEF; if_a.lp_cfg_vld = 1'b1;
    step();
    checks++; if (if_a.fifo_wr_en !== 1'b0 || crd_a !== 6'd32) begin errors++; $display("FAIL pres_down: got %b/%0d expected 0/32", if_a.fifo_wr_en, crd_a); end
    step();
    checks++; if (if_a.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL pres_down_hold: got %b expected 0", if_a.fifo_wr_en); end
    if_a.lp_cfg_vld = 1'b0; pres = 1'b1;
    step();
    beat_a(32'h0000_000D);
    beat_a(32'h0000_0000);
    checks++; if (if_a.fifo_wr_en !== 1'b1 || if_a.fifo_wdata !== 64'h00000000_0000000D) begin errors++; $display("FAIL pres_re_hdr: got %b/%h expected 1/000000000000000d", if_a.fifo_wr_en, if_a.fifo_wdata); end
    beat_a(32'h0000_000A);
    beat_a(32'h0000_000B);
    checks++; if (if_a.fifo_wr_en !== 1'b1 || if_a.fifo_wdata !== 64'h0000000B_0000000A) begin errors++; $display("FAIL pres_re_data: got %b/%h expected 1/0000000b0000000a", if_a.fifo_wr_en, if_a.fifo_wdata); end
    checks++; if (crd_a !== 6'd31) begin errors++; $display("FAIL pres_re_credit: got %0d expected 31", crd_a); end
  endtask

  task automatic test_nc16_fifo_full();
    do_reset();
    beat_b(16'h0011); step();
    beat_b(16'h2222); step(); step();
    beat_b(16'h3333); step();
    beat_b(16'h4444);
    checks++; if (if_b.fifo_wr_en !== 1'b1 || if_b.fifo_wdata !== 64'h4444_3333_2222_0011) begin errors++; $display("FAIL nc16_hdr: got %b/%h expected 1/4444333322220011", if_b.fifo_wr_en, if_b.fifo_wdata); end
    step();
    checks++; if (if_b.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL nc16_no_pad: got %b expected 0", if_b.fifo_wr_en); end
    beat_b(16'h5555); step();
    beat_b(16'h6666);
    beat_b(16'h7777); step(); step();
    if_b.fifo_full = 1'b1;
    beat_b(16'h8888);
    checks++; if (if_b.fifo_wr_en !== 1'b0) begin errors++; $display("FAIL nc16_full_supp: got %b expected 0", if_b.fifo_wr_en); end
    step();
    if_b.fifo_full = 1'b0;
    checks++; if (ovf_b !== 1'b1 || ovf_a !== 1'b0) begin errors++; $display("FAIL nc16_ovf_flag: got %b/%b expected 1/0", ovf_b, ovf_a); end
    beat_b(16'h0020);
    beat_b(16'h0000);
    beat_b(16'h0000);
    beat_b(16'h0000);
    checks++; if (if_b.fifo_wr_en !== 1'b1 || if_b.fifo_wdata !== 64'h0000_0000_0000_0020) begin errors++; $display("FAIL nc16_next_hdr: got %b/%h expected 1/0000000000000020", if_b.fifo_wr_en, if_b.fifo_wdata); end
    step();
    checks++; if (if_b.fifo_wr_en !== 1'b1 || if_b.fifo_wdata !== 64'h0) begin errors++; $display("FAIL nc16_next_pad: got %b/%h expected 1/0", if_b.fifo_wr_en, if_b.fifo_wdata); end
    checks++; if (crd_b !== 6'd30 || ovf_b !== 1'b1) begin errors++; $display("FAIL nc16_end: got %0d/%b expected 30/1", crd_b, ovf_b); end
  endtask

  initial begin
    test_reset();
    test_data_msg();
    test_back_to_back();
    test_underflow();
    test_credit_edges();
    test_presence_drop();
    test_nc16_fifo_full();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
